link_tx_arbiter: RTL and testbench
==================================

Name: link_tx_arbiter

Overview:
- Shares the single write port of the FPGA-to-Pi output ring buffer (9-bit words, bit 8 = address/data flag) among several ISA device front-ends: IDE, GUS, AdLib and spare.
- Each front-end issues short packets, typically an address word followed by a data word. The arbiter grants round-robin and never interleaves packets.
- Owns the write pointer and tracks free space against the link-side read pointer, so writes never overrun unread words.

Parameters:
- NREQ, 4, number of requesters
- AW, 12, ring buffer address width (depth 2^AW)
- DW, 9, word width
- TIMEOUT, 255, idle cycles allowed mid-packet before the grant is forcibly released

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  NREQ  requester i has a word presented
- req_data  in  NREQ*DW  word of requester i, at bits [i*DW +: DW]
- req_last  in  NREQ  presented word ends requester i's packet
- req_ready  out  NREQ  word of requester i accepted this cycle when valid&ready
- rd_ptr  in  AW  link-side read pointer, already synchronised to clk
- ram_wren  out  1  write strobe to ring buffer
- ram_wraddr  out  AW  write address
- ram_data  out  DW  write data
- level  out  AW+1  words stored, equal to wr_ptr - rd_ptr
- busy  out  1  a packet is in progress (LOCKED)
- timeout_err  out  1  sticky; set when a packet was aborted by timeout

Behaviour:
- Reset (async, rst=1) forces these values:
  - state IDLE; wr_ptr 0; last_grant NREQ-1.
  - req_ready 0; ram_wren 0; ram_wraddr 0; ram_data 0.
  - level 0; busy 0; timeout_err 0; idle counter 0.
  - Reset mid-packet discards the partial packet. Nothing already written is rolled back.
- Free space: free = 2^AW - 1 - ((wr_ptr - rd_ptr) mod 2^AW). One slot is always kept empty, so wr_ptr == rd_ptr means empty.
- State IDLE:
  - Search requesters starting at last_grant+1, wrapping at NREQ-1 to 0. The first one with req_valid=1 wins.
  - The win registers only if free >= 2. Otherwise stay in IDLE with no grant.
  - On a win: grant <= i, last_grant <= i, go to LOCKED next cycle. The arbitration cycle has req_ready all 0.
- State LOCKED:
  - req_ready[grant] = (free >= 1). This is combinational from registered state and pointers.
  - All other req_ready bits are 0.
  - On accept (valid&ready), next cycle: ram_wren=1, ram_wraddr=wr_ptr, ram_data=word, then wr_ptr <= wr_ptr+1 (mod 2^AW). Latency from accept to RAM write is 1 cycle.
  - Back-to-back accepts are allowed, giving 1 word per cycle.
  - Accept with req_last=1: return to IDLE next cycle. The next arbitration starts from grant+1, so a requester that just finished cannot win again while another requester is waiting.
  - Single-word packets (last on the first word) are legal.
- Timeout, LOCKED only:
  - The idle counter increments each cycle req_valid[grant]=0 and resets to 0 on each accept.
  - When it reaches TIMEOUT: go to IDLE, set timeout_err=1 (sticky until rst), clear the counter.
  - Words already written stay in the buffer.
  - Stalls due to free=0 with valid=1 do not count toward the timeout.
- ram_wren is 0 on every cycle without an accept in the previous cycle.
- level is registered from wr_ptr and rd_ptr each cycle. It lags by 1 cycle, and ranges 0 .. 2^AW-1.
- Wrap-around: wr_ptr and rd_ptr wrap modulo 2^AW. All comparisons use modular subtraction, so a wrapped rd_ptr gives correct free/level.
- Input rules:
  - req_data and req_last must stay stable while req_valid=1 and not accepted.
  - A requester dropping valid before accept is allowed, and it is not an error.
  - rd_ptr may advance on any cycle, including the same cycle as a write. free uses the current rd_ptr, which can only increase free, so it stays safe.

Test Plan:
- Single packet: requester 1 sends 0x170 then 0x001 (last) into an empty buffer → one idle arbitration cycle, then ram writes at addr 0,1 with data 0x170,0x001 on consecutive cycles; wr_ptr=2; level=2.
- Contention: requesters 0 and 2 both hold 2-word packets from reset → grant order 0 then 2; RAM holds 0a,0b,2a,2b with no interleave. Repeating with both valid again gives order 0 then 2 (start after last_grant=2 → 0).
- Fairness: requester 3 streams single-word packets continuously and requester 1 becomes valid → requester 1 is granted within one packet of requester 3.
- Full: AW=4, rd_ptr=0, 14 words written → free=1, no new grant in IDLE. Advancing rd_ptr to 1 makes free=2 and the grant proceeds. Mid-packet with free=0, ready stays 0 until rd_ptr moves.
- Wrap: start with wr_ptr=rd_ptr=2^AW-1 and write 3 words → addresses 0xFFF, 0x000, 0x001; level=3.
- Timeout/reset: TIMEOUT=8, grant holder drops valid after its first word → IDLE after 8 cycles, timeout_err=1, next requester granted. Asserting rst mid-packet clears all outputs to 0 immediately.

Source files
------------

// File: rtl/link_tx_arbiter.sv
// Round-robin arbiter that shares the ring-buffer write port among ISA front-ends.
// Packets are never interleaved, and writes never overrun words the link side has not read.
module link_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 12,
    parameter int DW      = 9,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic [NREQ-1:0]      req_last,
    output logic [NREQ-1:0]      req_ready,
    input  logic [AW-1:0]        rd_ptr,
    output logic                 ram_wren,
    output logic [AW-1:0]        ram_wraddr,
    output logic [DW-1:0]        ram_data,
    output logic [AW:0]          level,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state;
    logic [GW-1:0]   grant;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   idle_cnt;

    logic [AW-1:0]   used;
    logic [AW-1:0]   free;
    logic            sel_valid;
    logic            sel_last;
    logic [DW-1:0]   sel_data;
    logic            accept;
    logic            win_found;
    logic [GW-1:0]   win_idx;
    logic [GW:0]     idx;

    // One slot always stays empty, so free = depth-1-used is just the complement of used.
    assign used = wr_ptr - rd_ptr;
    assign free = ~used;

    assign sel_valid = req_valid[grant];
    assign sel_last  = req_last[grant];
    assign sel_data  = req_data[grant*DW +: DW];
    assign accept    = (state == LOCKED) && sel_valid && (free != '0);
    assign busy      = (state == LOCKED);

    always_comb begin
        req_ready = '0;
        if (state == LOCKED && free != '0)
            req_ready[grant] = 1'b1;
    end

    // Rotating priority search starting just after the most recent grant.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = {1'b0, grant} + (GW+1)'(k);
            if (idx >= (GW+1)'(NREQ))
                idx = idx - (GW+1)'(NREQ);
            if (!win_found && req_valid[idx[GW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = idx[GW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= GW'(NREQ-1);
            wr_ptr      <= '0;
            idle_cnt    <= '0;
            timeout_err <= 1'b0;
            ram_wren    <= 1'b0;
            ram_wraddr  <= '0;
            ram_data    <= '0;
            level       <= '0;
        end else begin
            level    <= {1'b0, used};
            ram_wren <= accept;
            if (accept) begin
                ram_wraddr <= wr_ptr;
                ram_data   <= sel_data;
                wr_ptr     <= wr_ptr + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (win_found && free > AW'(1)) begin
                        grant    <= win_idx;
                        state    <= LOCKED;
                        idle_cnt <= '0;
                    end
                end
                LOCKED: begin
                    // A valid word stalled on a full buffer neither counts nor clears the timeout.
                    if (accept) begin
                        idle_cnt <= '0;
                        if (sel_last)
                            state <= IDLE;
                    end else if (!sel_valid) begin
                        if (idle_cnt == CW'(TIMEOUT-1)) begin
                            state       <= IDLE;
                            timeout_err <= 1'b1;
                            idle_cnt    <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_link_tx_arbiter.sv
// Bench for link_tx_arbiter: a small depth-16 ring and short timeout so full, wrap and abort cases are quick.
module tb_link_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int AW    = 4;
    localparam int DW    = 9;
    localparam int TO    = 8;
    localparam int DEPTH = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_last;
    logic [NREQ-1:0]     req_ready;
    logic [AW-1:0]       rd_ptr;
    logic                ram_wren;
    logic [AW-1:0]       ram_wraddr;
    logic [DW-1:0]       ram_data;
    logic [AW:0]         level;
    logic                busy;
    logic                timeout_err;

    int tests = 0;
    int fails = 0;

    logic [DW:0]   q [NREQ][$];
    logic [NREQ-1:0] acc;
    int dut_log [$];
    int exp_log [$];

    int m_locked, m_owner, m_wptr, m_idle, m_err;
    int m_wren, m_addr, m_data, m_level;
    int m_log [$];

    link_tx_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .rd_ptr(rd_ptr),
        .ram_wren(ram_wren), .ram_wraddr(ram_wraddr), .ram_data(ram_data),
        .level(level), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Requester front-ends: each presents the head of its word queue until accepted.
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i] && q[i].size() > 0)
                void'(q[i].pop_front());
            acc[i] = 1'b0;
            if (q[i].size() > 0) begin
                req_valid[i]           = 1'b1;
                req_data[i*DW +: DW]   = q[i][0][DW-1:0];
                req_last[i]            = q[i][0][DW];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    end

    // Reference model: free space, rotating priority and timeout expressed with plain integers.
    always @(posedge clk or posedge rst) begin
        int used, free, cand, word;
        if (rst) begin
            m_locked = 0; m_owner = NREQ-1; m_wptr = 0; m_idle = 0; m_err = 0;
            m_wren = 0; m_addr = 0; m_data = 0; m_level = 0;
        end else begin
            used    = (m_wptr - int'(rd_ptr) + DEPTH) % DEPTH;
            free    = DEPTH - 1 - used;
            m_level = used;
            m_wren  = 0;
            if (m_locked == 0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    cand = (m_owner + k) % NREQ;
                    if (req_valid[cand]) begin
                        if (free >= 2) begin
                            m_locked = 1;
                            m_owner  = cand;
                            m_idle   = 0;
                        end
                        break;
                    end
                end
            end else if (req_valid[m_owner] && free >= 1) begin
                word   = int'(req_data[m_owner*DW +: DW]);
                m_wren = 1;
                m_addr = m_wptr;
                m_data = word;
                m_log.push_back(m_wptr * 512 + word);
                m_wptr = (m_wptr + 1) % DEPTH;
                m_idle = 0;
                if (req_last[m_owner])
                    m_locked = 0;
            end else if (!req_valid[m_owner]) begin
                m_idle++;
                if (m_idle >= TO) begin
                    m_locked = 0;
                    m_err    = 1;
                    m_idle   = 0;
                end
            end
        end
    end

    // Compare every cycle, mid-period, against the model.
    always @(negedge clk) begin
        int used_now;
        logic [NREQ-1:0] exp_ready;
        if (!rst) begin
            for (int i = 0; i < NREQ; i++)
                acc[i] = req_valid[i] & req_ready[i];
            used_now  = (m_wptr - int'(rd_ptr) + DEPTH) % DEPTH;
            exp_ready = '0;
            if (m_locked != 0 && (DEPTH - 1 - used_now) >= 1)
                exp_ready[m_owner] = 1'b1;
            checkOutput("req_ready", int'(req_ready), int'(exp_ready));
            checkOutput("ram_wren", int'(ram_wren), m_wren);
            if (m_wren != 0) begin
                checkOutput("ram_wraddr", int'(ram_wraddr), m_addr);
                checkOutput("ram_data", int'(ram_data), m_data);
            end
            checkOutput("level", int'(level), m_level);
            checkOutput("busy", int'(busy), m_locked);
            checkOutput("timeout_err", int'(timeout_err), m_err);
            if (ram_wren)
                dut_log.push_back(int'(ram_wraddr) * 512 + int'(ram_data));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic applyStimulus(input int r, input int data, input int last);
        logic [DW:0] w;
        w[DW-1:0] = data[DW-1:0];
        w[DW]     = last[0];
        q[r].push_back(w);
    endtask

    task automatic clearRequests();
        for (int i = 0; i < NREQ; i++)
            q[i].delete();
        acc       = '0;
        req_valid = '0;
        req_last  = '0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ready"}, int'(req_ready), 0);
        checkOutput({tag, "_wren"}, int'(ram_wren), 0);
        checkOutput({tag, "_wraddr"}, int'(ram_wraddr), 0);
        checkOutput({tag, "_data"}, int'(ram_data), 0);
        checkOutput({tag, "_level"}, int'(level), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_err"}, int'(timeout_err), 0);
    endtask

    task automatic applyReset();
        rst = 1'b1;
        clearRequests();
        rd_ptr = '0;
        #1;
        checkResetOutputs("reset");
        tick(2);
        rst = 1'b0;
        dut_log.delete();
        m_log.delete();
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < NREQ; i++)
            n += q[i].size();
        return n;
    endfunction

    task automatic waitDrain(input string name, input int budget);
        int n = 0;
        while (pending() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        if (n >= budget) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s_drain: %0d words still queued after %0d cycles", name, pending(), budget);
        end
        tick(4);
    endtask

    task automatic checkLog(input string name);
        checkOutput({name, "_dut_count"}, dut_log.size(), exp_log.size());
        checkOutput({name, "_model_count"}, m_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size(); i++) begin
            checkOutput($sformatf("%s_dut_w%0d", name, i), (i < dut_log.size()) ? dut_log[i] : -1, exp_log[i]);
            checkOutput($sformatf("%s_model_w%0d", name, i), (i < m_log.size()) ? m_log[i] : -1, exp_log[i]);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; rd_ptr = '0; acc = '0;
        tick(1);
        applyReset();
        tick(2);
        checkResetOutputs("idle_after_reset");

        // Single two-word packet from requester 1.
        applyStimulus(1, 'h170, 0);
        applyStimulus(1, 'h001, 1);
        waitDrain("single", 50);
        exp_log = '{0*512 + 'h170, 1*512 + 'h001};
        checkLog("single");
        checkOutput("single_level", int'(level), 2);

        // Contention between requesters 0 and 2, twice.
        applyReset();
        applyStimulus(0, 'h0A0, 0); applyStimulus(0, 'h0A1, 1);
        applyStimulus(2, 'h0C0, 0); applyStimulus(2, 'h0C1, 1);
        waitDrain("contend1", 50);
        applyStimulus(0, 'h0A2, 0); applyStimulus(0, 'h0A3, 1);
        applyStimulus(2, 'h0C2, 0); applyStimulus(2, 'h0C3, 1);
        waitDrain("contend2", 50);
        exp_log = '{0*512+'h0A0, 1*512+'h0A1, 2*512+'h0C0, 3*512+'h0C1,
                    4*512+'h0A2, 5*512+'h0A3, 6*512+'h0C2, 7*512+'h0C3};
        checkLog("contend");

        // Requester 3 streams single-word packets; requester 1 joins one cycle later.
        applyReset();
        for (int k = 0; k < 6; k++)
            applyStimulus(3, 'h130 + k, 1);
        tick(1);
        applyStimulus(1, 'h1AA, 1);
        waitDrain("fair", 80);
        exp_log = '{0*512+'h130, 1*512+'h1AA, 2*512+'h131, 3*512+'h132,
                    4*512+'h133, 5*512+'h134, 6*512+'h135};
        checkLog("fair");

        // Fill to one free slot, block arbitration, then stall mid-packet at zero free and wrap.
        applyReset();
        for (int k = 0; k < 14; k++)
            applyStimulus(0, 'h100 + k, (k == 13) ? 1 : 0);
        waitDrain("fill", 80);
        applyStimulus(2, 'h1E0, 0);
        applyStimulus(2, 'h1E1, 0);
        applyStimulus(2, 'h1E2, 1);
        tick(6);
        checkOutput("full_no_grant_busy", int'(busy), 0);
        checkOutput("full_no_grant_level", int'(level), 14);
        rd_ptr = 4'd1;
        tick(6);
        checkOutput("stall_busy", int'(busy), 1);
        checkOutput("stall_ready", int'(req_ready), 0);
        tick(12);
        checkOutput("stall_no_timeout", int'(timeout_err), 0);
        checkOutput("stall_still_busy", int'(busy), 1);
        rd_ptr = 4'd4;
        waitDrain("wrap", 40);
        exp_log.delete();
        for (int k = 0; k < 14; k++)
            exp_log.push_back(k * 512 + 'h100 + k);
        exp_log.push_back(14 * 512 + 'h1E0);
        exp_log.push_back(15 * 512 + 'h1E1);
        exp_log.push_back(0 * 512 + 'h1E2);
        checkLog("full");
        checkOutput("wrap_level", int'(level), 13);

        // Grant holder abandons its packet; timeout hands the port to requester 2.
        applyReset();
        applyStimulus(1, 'h150, 0);
        applyStimulus(2, 'h160, 0);
        applyStimulus(2, 'h161, 1);
        waitDrain("timeout", 60);
        exp_log = '{0*512+'h150, 1*512+'h160, 2*512+'h161};
        checkLog("timeout");
        checkOutput("timeout_err_set", int'(timeout_err), 1);
        checkOutput("timeout_idle", int'(busy), 0);

        // Asynchronous reset in the middle of a packet.
        dut_log.delete();
        for (int k = 0; k < 4; k++)
            applyStimulus(0, 'h170 + k, (k == 3) ? 1 : 0);
        begin
            int n = 0;
            while (dut_log.size() < 2 && n < 30) begin
                tick(1);
                n++;
            end
        end
        checkOutput("midpkt_busy", int'(busy), 1);
        rst = 1'b1;
        clearRequests();
        #1;
        checkResetOutputs("midpkt_reset");
        tick(2);
        rst = 1'b0;
        dut_log.delete();
        m_log.delete();
        applyStimulus(3, 'h1FF, 1);
        waitDrain("after_reset", 40);
        exp_log = '{0*512 + 'h1FF};
        checkLog("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
